control_sequencer: RTL

- Microcoded control unit for the 8-bit shared-bus CPU.
- Holds the instruction register (IR) and the micro-step counter.
- Decodes opcode and step into the per-cycle control word for the program counter, memory, A/B registers, ALU and output register. This includes the memory's write, write_addr and read strobes.
- Sits directly upstream of the memory block. It is the only source of its control strobes and it drives the instruction operand onto the bus as a memory address.

---
 rtl/control_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control unit for the 8-bit shared-bus CPU
//
// Holds the instruction register and the micro-step counter. It decodes
// (step, opcode, flags) into the per-cycle control word for the PC, memory,
// A/B registers, ALU and output register. The memory control strobes come
// only from this block. The block drives the instruction operand onto the
// shared bus as a memory address or immediate value.
//
// Optional feature macro: COND_JUMP_EN enables JC/JZ and the flags_write
// strobe. When it is undefined, JC/JZ decode as NOP and flags_write is 0.
//
// Ports:
//   clock          system clock, all state changes on posedge
//   reset          asynchronous, active-high
//   bus            shared tri-state bus (IR load source, operand drive)
//   carry_flag     ALU carry flag (conditional jumps only)
//   zero_flag      ALU zero flag (conditional jumps only)
//   pc_out         PC drives bus
//   pc_inc         PC increments
//   pc_load        PC loads bus[3:0]
//   mem_write_addr memory latches address from bus
//   mem_read       memory drives bus
//   mem_write      memory stores bus
//   a_write        A register load
//   a_out          A register drives bus
//   b_write        B register load
//   alu_out        ALU drives bus
//   alu_sub        ALU subtract select
//   flags_write    flags register load
//   out_write      output register load
//   halted         CPU stopped (cleared only by reset)

module control_sequencer #(
    parameter int BUS_W     = 8,
    parameter int OPERAND_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [BUS_W-1:0] bus,
    input  logic             carry_flag,
    input  logic             zero_flag,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_write_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic             a_write,
    output logic             a_out,
    output logic             b_write,
    output logic             alu_out,
    output logic             alu_sub,
    output logic             flags_write,
    output logic             out_write,
    output logic             halted
);

    localparam int OPC_W = BUS_W - OPERAND_W;

    localparam logic [OPC_W-1:0] OP_NOP = 'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 'h3;
    localparam logic [OPC_W-1:0] OP_STA = 'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 'hF;

    logic [BUS_W-1:0] ir;
    logic [2:0]       step;
    logic [OPC_W-1:0] opcode;

    // Internal strobes: IR load from bus, IR operand onto bus.
    logic ir_write;
    logic ir_out;
    // Sequencing: close the instruction on this edge / enter halt on this edge.
    logic step_end;
    logic do_halt;

    assign opcode = ir[BUS_W-1:OPERAND_W];

`ifndef COND_JUMP_EN
    // The flags only matter to the conditional jumps.
    logic unused_flags;
    assign unused_flags = carry_flag ^ zero_flag;
`endif

    always_comb begin
        pc_out         = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        mem_write_addr = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        a_write        = 1'b0;
        a_out          = 1'b0;
        b_write        = 1'b0;
        alu_out        = 1'b0;
        alu_sub        = 1'b0;
        flags_write    = 1'b0;
        out_write      = 1'b0;
        ir_write       = 1'b0;
        ir_out         = 1'b0;
        step_end       = 1'b0;
        do_halt        = 1'b0;

        // Reset and halt both silence the whole control word. During reset
        // this also releases the bus in the same cycle.
        if (!reset && !halted) begin
            case (step)
                3'd0: begin
                    pc_out         = 1'b1;
                    mem_write_addr = 1'b1;
                end
                3'd1: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out         = 1'b1;
                            mem_write_addr = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out   = 1'b1;
                            a_write  = 1'b1;
                            step_end = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out   = 1'b1;
                            pc_load  = 1'b1;
                            step_end = 1'b1;
                        end
`ifdef COND_JUMP_EN
                        OP_JC: begin
                            ir_out   = carry_flag;
                            pc_load  = carry_flag;
                            step_end = 1'b1;
                        end
                        OP_JZ: begin
                            ir_out   = zero_flag;
                            pc_load  = zero_flag;
                            step_end = 1'b1;
                        end
`endif
                        OP_OUT: begin
                            a_out     = 1'b1;
                            out_write = 1'b1;
                            step_end  = 1'b1;
                        end
                        OP_HLT: begin
                            do_halt = 1'b1;
                        end
                        // NOP, undefined opcodes and, when the feature is
                        // disabled, JC/JZ.
                        default: begin
                            step_end = 1'b1;
                        end
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            mem_read = 1'b1;
                            a_write  = 1'b1;
                            step_end = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            mem_read = 1'b1;
                            b_write  = 1'b1;
                        end
                        OP_STA: begin
                            a_out     = 1'b1;
                            mem_write = 1'b1;
                            step_end  = 1'b1;
                        end
                        // Unreachable for the other opcodes. Close the
                        // instruction anyway.
                        default: begin
                            step_end = 1'b1;
                        end
                    endcase
                end
                default: begin
                    // T4 always ends. Steps 5-7 are never entered.
                    step_end = 1'b1;
                    if (step == 3'd4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
                        alu_out = 1'b1;
                        a_write = 1'b1;
                        alu_sub = (opcode == OP_SUB);
`ifdef COND_JUMP_EN
                        flags_write = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    assign bus = ir_out ? {{OPC_W{1'b0}}, ir[OPERAND_W-1:0]} : {BUS_W{1'bz}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir     <= '0;
            step   <= 3'd0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (ir_write) begin
                ir <= bus;
            end
            // On the halt edge the step counter holds at T2.
            if (do_halt) begin
                halted <= 1'b1;
            end else if (step_end) begin
                step <= 3'd0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule
